// File: rtl/cursor_overlay.sv
// Text-mode cursor overlay: blink timing, cursor hit, reverse video, pixel pipe.
// Ports: clk/clr, px_en, blanking, row/col/line, char_pixel, cursor load, mode/invert -> video.
module cursor_overlay #(
  parameter int ROW_BITS     = 5,
  parameter int COL_BITS     = 7,
  parameter int LINE_BITS    = 4,
  parameter int CHAR_LINES   = 16,
  parameter int UL_LINES     = 2,
  parameter int BLINK_FRAMES = 15,
  parameter int PIPE         = 2
) (
  input  logic                 clk,
  input  logic                 clr,
  input  logic                 px_en,
  input  logic                 hblank,
  input  logic                 vblank,
  input  logic [ROW_BITS-1:0]  row,
  input  logic [COL_BITS-1:0]  col,
  input  logic [LINE_BITS-1:0] line,
  input  logic                 char_pixel,
  input  logic [COL_BITS-1:0]  new_cursor_x,
  input  logic [ROW_BITS-1:0]  new_cursor_y,
  input  logic                 new_cursor_wen,
  input  logic [1:0]           mode,
  input  logic                 invert,
  output logic                 video,
  output logic                 blink_on,
  output logic [COL_BITS-1:0]  cursor_x,
  output logic [ROW_BITS-1:0]  cursor_y
);

  localparam int CW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(BLINK_FRAMES - 1);
  localparam logic [LINE_BITS-1:0] UL_START =
    LINE_BITS'(CHAR_LINES - UL_LINES);

  logic          vblank_q;
  logic          seen_low;
  logic          frame_tick;
  logic [CW-1:0] cnt;
  logic [PIPE-1:0] pipe;

  // A rise only counts once vblank has been seen low after reset, so a
  // vblank held high across reset release cannot fake a frame.
  assign frame_tick = vblank & ~vblank_q & seen_low;

  always_ff @(posedge clk) begin
    if (!clr) begin
      cursor_x <= '0;
      cursor_y <= '0;
      vblank_q <= 1'b0;
      seen_low <= 1'b0;
      cnt      <= '0;
      blink_on <= 1'b1;
    end else begin
      vblank_q <= vblank;
      if (!vblank)
        seen_low <= 1'b1;
      if (new_cursor_wen) begin
        cursor_x <= new_cursor_x;
        cursor_y <= new_cursor_y;
        cnt      <= '0;
        blink_on <= 1'b1;
      end else if (frame_tick) begin
        if (cnt == CNT_LAST) begin
          cnt      <= '0;
          blink_on <= ~blink_on;
        end else begin
          cnt <= cnt + 1'b1;
        end
      end
    end
  end

  logic hit;
  logic cur_px;
  logic comp;

  assign hit = (col == cursor_x) && (row == cursor_y);

  always_comb begin
    cur_px = 1'b0;
    unique case (mode)
      2'b00: cur_px = 1'b0;
      2'b01: cur_px = hit;
      2'b10: cur_px = hit & blink_on;
      2'b11: cur_px = hit & blink_on & (line >= UL_START);
      default: cur_px = 1'b0;
    endcase
  end

  assign comp = (hblank | vblank) ? 1'b0 : (char_pixel ^ cur_px ^ invert);

  always_ff @(posedge clk) begin
    if (!clr) begin
      pipe <= '0;
    end else if (px_en) begin
      pipe[0] <= comp;
      for (int i = 1; i < PIPE; i++)
        pipe[i] <= pipe[i-1];
    end
  end

  assign video = pipe[PIPE-1];

endmodule

// File: tb/tb_cursor_overlay.sv
// Directed bench for cursor_overlay (BLINK_FRAMES=3, PIPE=2).
// Drives inputs 1 time unit after posedge and checks there as well.
module tb_cursor_overlay;

  logic       clk = 1'b0;
  logic       clr, px_en, hblank, vblank, char_pixel;
  logic [4:0] row, new_cursor_y, cursor_y;
  logic [6:0] col, new_cursor_x, cursor_x;
  logic [3:0] line;
  logic       new_cursor_wen, invert, video, blink_on;
  logic [1:0] mode;

  int tests = 0;
  int fails = 0;
  logic expb;

  always #5 clk = ~clk;

  cursor_overlay #(
    .BLINK_FRAMES(3),
    .PIPE(2)
  ) dut (
    .clk(clk), .clr(clr), .px_en(px_en),
    .hblank(hblank), .vblank(vblank),
    .row(row), .col(col), .line(line),
    .char_pixel(char_pixel),
    .new_cursor_x(new_cursor_x), .new_cursor_y(new_cursor_y),
    .new_cursor_wen(new_cursor_wen),
    .mode(mode), .invert(invert),
    .video(video), .blink_on(blink_on),
    .cursor_x(cursor_x), .cursor_y(cursor_y)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic vpulse();
    vblank = 1'b1;
    step();
    vblank = 1'b0;
    step();
  endtask

  initial begin
    clr = 1'b0; px_en = 1'b1; hblank = 1'b0; vblank = 1'b0;
    row = '0; col = '0; line = '0; char_pixel = 1'b0;
    new_cursor_x = '0; new_cursor_y = '0; new_cursor_wen = 1'b0;
    mode = 2'b01; invert = 1'b0;
    step(); step();
    chk("rst_video", video, 0);
    chk("rst_blink", blink_on, 1);
    chk("rst_cx", cursor_x, 0);
    chk("rst_cy", cursor_y, 0);

    // block steady cursor at (0,0): two-tick latency
    clr = 1'b1;
    step();
    chk("lat_t1", video, 0);
    step();
    chk("lat_t2", video, 1);

    // reverse video and blanking
    col = 7'd5; invert = 1'b1; hblank = 1'b1; char_pixel = 1'b1;
    step(); step();
    chk("inv_hblank", video, 0);
    hblank = 1'b0; char_pixel = 1'b0;
    step(); step();
    chk("inv_plain", video, 1);
    char_pixel = 1'b1;
    step(); step();
    chk("inv_char", video, 0);
    invert = 1'b0;

    // underline cursor
    col = '0; mode = 2'b11; char_pixel = 1'b1;
    line = 4'd0;  step(); step(); chk("ul_line0", video, 1);
    line = 4'd13; step(); step(); chk("ul_line13", video, 1);
    line = 4'd14; step(); step(); chk("ul_line14", video, 0);
    line = 4'd15; step(); step(); chk("ul_line15", video, 0);
    line = 4'd0; char_pixel = 1'b0;

    // cursor move
    new_cursor_x = 7'd3; new_cursor_y = 5'd2; new_cursor_wen = 1'b1;
    step();
    new_cursor_wen = 1'b0;
    chk("mv_cx", cursor_x, 3);
    chk("mv_cy", cursor_y, 2);
    mode = 2'b01; col = 7'd3; row = 5'd2;
    step(); step();
    chk("mv_hit", video, 1);
    col = '0; row = '0;
    step(); step();
    chk("mv_old", video, 0);

    // blink every 3 frames
    mode = 2'b10; col = 7'd3; row = 5'd2;
    expb = 1'b1;
    for (int k = 1; k <= 9; k++) begin
      vpulse();
      if (k % 3 == 0) expb = ~expb;
      chk($sformatf("blink_%0d", k), blink_on, expb);
      step();
      chk($sformatf("blink_vid_%0d", k), video, expb);
    end

    // move during frame tick with counter=2, blink_on=0
    vpulse(); vpulse();
    chk("pre_mv_blink", blink_on, 0);
    vblank = 1'b1; new_cursor_wen = 1'b1;
    new_cursor_x = 7'd7; new_cursor_y = 5'd4;
    step();
    vblank = 1'b0; new_cursor_wen = 1'b0;
    chk("wen_blink", blink_on, 1);
    chk("wen_cx", cursor_x, 7);
    chk("wen_cy", cursor_y, 4);
    step();
    vpulse(); vpulse();
    chk("wen_cnt2", blink_on, 1);
    vpulse();
    chk("wen_cnt3", blink_on, 0);

    // reset with vblank held high across release
    vblank = 1'b1; clr = 1'b0;
    step();
    chk("rst2_video", video, 0);
    chk("rst2_blink", blink_on, 1);
    chk("rst2_cx", cursor_x, 0);
    clr = 1'b1;
    step(); step();
    vblank = 1'b0;
    step();
    vpulse(); vpulse();
    chk("fresh_2", blink_on, 1);
    vpulse();
    chk("fresh_3", blink_on, 0);

    // sparse px_en: fill with zeros then a cursor pixel
    mode = 2'b01; row = '0; col = 7'd1;
    step(); step();
    px_en = 1'b0;
    col = '0;
    step(); step();
    px_en = 1'b1; step(); px_en = 1'b0;
    chk("sp_t1", video, 0);
    step(); chk("sp_idle1", video, 0);
    step(); chk("sp_idle2", video, 0);
    px_en = 1'b1; step(); px_en = 1'b0;
    chk("sp_t2", video, 1);
    step(); chk("sp_hold", video, 1);

    // reset mid-stream with px_en low
    clr = 1'b0;
    step();
    chk("sp_rst", video, 0);
    clr = 1'b1;
    step(); step();
    px_en = 1'b1; step(); px_en = 1'b0;
    chk("sp_rel_t1", video, 0);
    step(); step();
    px_en = 1'b1; step(); px_en = 1'b0;
    chk("sp_rel_t2", video, 1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
